// File: rtl/bus_decoder_n.sv
// bus_decoder_n: registered address decoder with per-slave ready handshake, wait states and timeout/error response.
// Optional feature macro BUS_ERR_CAPTURE_EN adds a sticky first-fault address capture (err_valid/err_addr).
module bus_decoder_n #(
    parameter int NUM_SLAVES     = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
        {32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_SIZE = {4{32'h0001_0000}},
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_W-1:0]            m_addr,
    input  logic [DATA_W-1:0]            m_wdata,
    input  logic [DATA_W/8-1:0]          m_wstrb,
    input  logic                         m_ren,
    input  logic                         m_wen,
    output logic [DATA_W-1:0]            m_rdata,
    output logic                         m_ready,
    output logic                         m_err,
    output logic [NUM_SLAVES-1:0]        s_sel,
    output logic [NUM_SLAVES-1:0]        s_ren,
    output logic [NUM_SLAVES-1:0]        s_wen,
    output logic [ADDR_W-1:0]            s_addr,
    output logic [DATA_W-1:0]            s_wdata,
    output logic [DATA_W/8-1:0]          s_wstrb,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic                         err_clr,
    output logic                         err_valid,
    output logic [ADDR_W-1:0]            err_addr
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    idx_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                wr_r;

    logic                hit_s;
    logic                take_s;
    logic [IDX_W-1:0]    hit_idx_s;
    logic [ADDR_W-1:0]   hit_off_s;
    logic [NUM_SLAVES-1:0] hit_oh_s;
    logic [DATA_W-1:0]   rdata_sel_s;

    // Window membership, compared one bit wider than the address so base+size cannot wrap.
    function automatic logic in_window(input logic [ADDR_W-1:0] addr, input int idx);
        logic [ADDR_W:0] lo;
        logic [ADDR_W:0] hi;
        lo = {1'b0, SLAVE_BASE[idx*ADDR_W +: ADDR_W]};
        hi = lo + {1'b0, SLAVE_SIZE[idx*ADDR_W +: ADDR_W]};
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

    // Address decode: first (lowest-index) matching window wins on overlap.
    always_comb begin
        hit_s     = 1'b0;
        take_s    = 1'b0;
        hit_idx_s = '0;
        hit_off_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            take_s    = !hit_s && in_window(m_addr, i);
            hit_idx_s = take_s ? IDX_W'(i) : hit_idx_s;
            hit_off_s = take_s ? (m_addr - SLAVE_BASE[i*ADDR_W +: ADDR_W]) : hit_off_s;
            hit_s     = hit_s | take_s;
        end
    end

    assign hit_oh_s    = NUM_SLAVES'(1) << hit_idx_s;
    assign rdata_sel_s = s_rdata[idx_r*DATA_W +: DATA_W];

    // Transaction sequencer: latch the request, hold slave strobes, return a one-cycle response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= '0;
            cnt_r   <= '0;
            wr_r    <= 1'b0;
            s_sel   <= '0;
            s_ren   <= '0;
            s_wen   <= '0;
            s_addr  <= '0;
            s_wdata <= '0;
            s_wstrb <= '0;
            m_ready <= 1'b0;
            m_err   <= 1'b0;
            m_rdata <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                    if (m_ren || m_wen) begin
                        idx_r   <= hit_idx_s;
                        wr_r    <= m_wen;
                        s_addr  <= hit_off_s;
                        s_wdata <= m_wdata;
                        s_wstrb <= m_wstrb;
                        cnt_r   <= '0;
                        if (hit_s) begin
                            state_r <= ACCESS;
                            s_sel   <= hit_oh_s;
                            s_wen   <= m_wen ? hit_oh_s : '0;
                            s_ren   <= m_wen ? '0 : hit_oh_s;
                        end else begin
                            state_r <= RESP;
                            m_ready <= 1'b1;
                            m_err   <= 1'b1;
                            m_rdata <= '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    if (s_ready[idx_r]) begin
                        state_r <= RESP;
                        s_sel   <= '0;
                        s_ren   <= '0;
                        s_wen   <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b0;
                        m_rdata <= wr_r ? m_rdata : rdata_sel_s;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt_r == CNT_LAST)) begin
                        state_r <= RESP;
                        s_sel   <= '0;
                        s_ren   <= '0;
                        s_wen   <= '0;
                        m_ready <= 1'b1;
                        m_err   <= 1'b1;
                        m_rdata <= '0;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    s_sel   <= '0;
                    s_ren   <= '0;
                    s_wen   <= '0;
                    m_ready <= 1'b0;
                    m_err   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_ERR_CAPTURE_EN
    logic [ADDR_W-1:0] req_addr_r;

    // Full master address of the transaction in flight, needed when a mapped slave times out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_addr_r <= '0;
        end else if ((state_r == IDLE) && (m_ren || m_wen)) begin
            req_addr_r <= m_addr;
        end else begin
            req_addr_r <= req_addr_r;
        end
    end

    // Sticky first-fault capture; a clear in the same cycle beats a new capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else if (m_ready && m_err && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= req_addr_r;
        end else begin
            err_valid <= err_valid;
            err_addr  <= err_addr;
        end
    end
`else
    logic unused_err_clr_s;
    assign unused_err_clr_s = err_clr;
    assign err_valid        = 1'b0;
    assign err_addr         = '0;
`endif

endmodule

// File: tb/tb_bus_decoder_n.sv
// Scoreboard bench for bus_decoder_n: randomized transactions against an address-map reference model,
// with a reactive slave model supplying wait states and read data.
`timescale 1ns/1ps
module tb_bus_decoder_n;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;
`ifdef BUS_ERR_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [31:0]       m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
    logic [3:0]        m_wstrb, s_wstrb, s_sel, s_ren, s_wen, s_ready;
    logic              m_ren, m_wen, m_ready, m_err, err_clr, err_valid;
    logic [NS*DW-1:0]  s_rdata;

    bus_decoder_n dut (
        .clk(clk), .rst_n(rst_n), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_ren(m_ren), .m_wen(m_wen), .m_rdata(m_rdata), .m_ready(m_ready), .m_err(m_err),
        .s_sel(s_sel), .s_ren(s_ren), .s_wen(s_wen), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_rdata(s_rdata), .s_ready(s_ready), .err_clr(err_clr),
        .err_valid(err_valid), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          idx;
        bit          wr;
        logic [31:0] off;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          err;
        logic [31:0] rdata;
        int          lat;
        int          act;
        int          t0;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] bases [0:3] = '{32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 32'h4000_0000};
    int          n_checks = 0;
    int          n_errs   = 0;
    int          cyc      = 0;
    int          act_cnt  = 0;
    int          acc_k    = 0;
    int          plan_wait;
    logic [31:0] plan_rdata;
    logic [31:0] last_rd = 32'h0;
    logic [3:0]  e_sel;
    bit          cap_pend = 1'b0;
    logic [31:0] cap_addr = 32'h0;
    bit          mev = 1'b0;
    logic [31:0] mea = 32'h0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Address map reference: 64 KiB windows, lowest index first, no wrap.
    function automatic int find_slave(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ({1'b0, a} >= {1'b0, bases[i]} && {1'b0, a} < ({1'b0, bases[i]} + 33'h0_0001_0000))
                return i;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: selected slave answers after plan_wait access cycles; others emit noise.
    always @(negedge clk) begin
        for (int i = 0; i < NS; i++) begin
            s_rdata[i*DW +: DW] = $urandom;
            s_ready[i]          = ($urandom_range(0, 3) == 0);
        end
        if (s_sel != 4'b0000) begin
            for (int i = 0; i < NS; i++) begin
                if (s_sel[i]) begin
                    s_ready[i]          = (acc_k == plan_wait);
                    s_rdata[i*DW +: DW] = plan_rdata;
                end
            end
            acc_k++;
        end else begin
            acc_k = 0;
        end
    end

    // Error-capture reference, advanced on the same edge the DUT samples.
    always @(posedge clk) begin
        if (!rst_n || err_clr) begin
            mev <= 1'b0;
            mea <= 32'h0;
        end else if (cap_pend && !mev) begin
            mev <= 1'b1;
            mea <= cap_addr;
        end
    end

    // Monitor: checks slave-side strobes while active and pops the scoreboard on every m_ready.
    always @(negedge clk) begin
        cap_pend = 1'b0;
        if (rst_n === 1'b1) begin
            if (sb_q.size() != 0 && (s_sel != 4'b0 || s_ren != 4'b0 || s_wen != 4'b0)) begin
                mon_e = sb_q[0];
                act_cnt++;
                e_sel = (mon_e.idx >= 0) ? (4'b0001 << mon_e.idx) : 4'b0000;
                chk("strobes", {s_sel, s_ren, s_wen, s_wstrb, s_addr, s_wdata},
                    {e_sel, mon_e.wr ? 4'b0000 : e_sel, mon_e.wr ? e_sel : 4'b0000,
                     mon_e.wstrb, mon_e.off, mon_e.wdata});
            end
            if (m_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_m_ready", 128'd1, 128'd0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("m_err", m_err, mon_e.err);
                    chk("m_rdata", m_rdata, mon_e.rdata);
                    chk("latency", cyc - mon_e.t0, mon_e.lat);
                    chk("strobe_cycles", act_cnt, mon_e.act);
                    chk("resp_strobes_idle", {s_sel, s_ren, s_wen}, 128'd0);
                    cap_pend = mon_e.err;
                    cap_addr = mon_e.addr;
                end
                act_cnt = 0;
            end
            chk("err_capture", {err_valid, err_addr}, CAP ? {mev, mea} : 33'h0);
        end
    end

    task automatic issue(input logic [31:0] a, input bit r, input bit w, input logic [31:0] wd,
                         input logic [3:0] ws, input int wt, input logic [31:0] rd);
        exp_t e;
        int   k;
        int   n;
        k       = find_slave(a);
        e.addr  = a;
        e.idx   = k;
        e.wr    = w;
        e.off   = 32'h0;
        e.wdata = wd;
        e.wstrb = ws;
        if (k >= 0) e.off = a - bases[k];
        if (k < 0) begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = 1; e.act = 0;
        end else if (wt >= TMO) begin
            e.err = 1'b1; e.rdata = 32'h0; e.lat = TMO + 1; e.act = TMO;
        end else begin
            e.err = 1'b0; e.rdata = w ? last_rd : rd; e.lat = wt + 2; e.act = wt + 1;
        end
        last_rd = e.rdata;
        @(negedge clk);
        plan_wait  = wt;
        plan_rdata = rd;
        e.t0       = cyc;
        m_addr = a; m_ren = r; m_wen = w; m_wdata = wd; m_wstrb = ws;
        sb_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_ready !== 1'b1 && n < 40);
        if (m_ready !== 1'b1) begin
            chk("handshake_timeout", 128'd0, 128'd1);
            sb_q.delete();
        end
        m_ren = 1'b0;
        m_wen = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          sel;
        int          op;
        int          wt;
        rst_n = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_wstrb = 4'h0;
        m_ren = 1'b0; m_wen = 1'b0; err_clr = 1'b0; plan_wait = 0; plan_rdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_ready_err", {m_ready, m_err}, 128'd0);
        chk("reset_rdata", m_rdata, 128'd0);
        chk("reset_strobes", {s_sel, s_ren, s_wen}, 128'd0);
        chk("reset_slave_bus", {s_addr, s_wdata, s_wstrb}, 128'd0);
        chk("reset_errcap", {err_valid, err_addr}, 128'd0);
        rst_n = 1'b1;

        issue(32'h2000_0010, 1'b1, 1'b0, 32'h0, 4'h0, 0, 32'hDEAD_BEEF);
        issue(32'h1000_0004, 1'b0, 1'b1, 32'h1234_5678, 4'b0011, 3, 32'h0BAD_F00D);
        issue(32'h5000_0000, 1'b1, 1'b0, 32'h0, 4'h0, 0, 32'h1111_1111);
        issue(32'h3000_0040, 1'b1, 1'b0, 32'h0, 4'h0, 99, 32'h2222_2222);
        issue(32'h1000_FFFF, 1'b1, 1'b0, 32'h0, 4'h0, 1, 32'hCAFE_0001);
        issue(32'h1001_0000, 1'b1, 1'b0, 32'h0, 4'h0, 0, 32'h3333_3333);
        issue(32'h3000_0000, 1'b1, 1'b1, 32'hA5A5_5A5A, 4'b1111, 2, 32'h4444_4444);
        issue(32'h4000_0100, 1'b1, 1'b0, 32'h0, 4'h0, 5, 32'h5555_AAAA);
        issue(32'hFFFF_FFFF, 1'b0, 1'b1, 32'h6666_6666, 4'b1000, 0, 32'h7777_7777);
        pulse_clr();
        issue(32'h0FFF_FFFF, 1'b1, 1'b0, 32'h0, 4'h0, 0, 32'h8888_8888);

        // Reset while a slave is being accessed: abandoned, no response.
        @(negedge clk);
        m_addr = 32'h3000_0100; m_ren = 1'b1; plan_wait = 99;
        repeat (3) @(negedge clk);
        chk("mid_access_ren", s_ren, 128'h4);
        rst_n = 1'b0; m_ren = 1'b0;
        @(negedge clk);
        chk("rst_abort_strobes", {s_sel, s_ren, s_wen, m_ready, m_err}, 128'd0);
        chk("rst_abort_rdata", m_rdata, 128'd0);
        rst_n   = 1'b1;
        last_rd = 32'h0;
        repeat (4) @(negedge clk);

        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 5);
            if (sel < 4) a = bases[sel] + ($urandom & 32'h0000_FFFF);
            else if (sel == 4) a = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 32'h0FFF_FFFF)
                                                                : 32'h5000_0000 + $urandom_range(0, 32'hAFFF_FFFF);
            else begin
                a = bases[$urandom_range(0, 3)];
                case ($urandom_range(0, 2))
                    0:       a = a + 32'h0000_FFFF;
                    1:       a = a + 32'h0001_0000;
                    default: a = a - 32'h1;
                endcase
            end
            op = $urandom_range(0, 2);
            wt = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 2) : $urandom_range(0, 5);
            issue(a, op != 1, op != 0, $urandom, 4'($urandom), wt, $urandom);
            if ($urandom_range(0, 7) == 0) pulse_clr();
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 128'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
